// File: rtl/price_level_book.sv
// rtl/price_level_book.sv - two-sided sorted price-level book with aggregated shares
// Three-cycle IDLE/FIND/UPDATE pipeline; top-of-book and level counts are registered from the ladders.
module price_level_book #(
  parameter int DEPTH   = 8,
  parameter int PRICE_W = 32,
  parameter int QTY_W   = 32
) (
  input  logic                       clkIn,
  input  logic                       rstIn,
  input  logic                       msgValidIn,
  input  logic                       msgReduceIn,
  input  logic                       buySellIn,
  input  logic [PRICE_W-1:0]         priceIn,
  input  logic [QTY_W-1:0]           sharesIn,
  output logic                       readyOut,
  output logic                       doneOut,
  output logic                       dropOut,
  output logic                       missOut,
  output logic                       topBuyValidOut,
  output logic                       topSellValidOut,
  output logic [PRICE_W-1:0]         topBuyPriceOut,
  output logic [PRICE_W-1:0]         topSellPriceOut,
  output logic [QTY_W-1:0]           topBuyQtyOut,
  output logic [QTY_W-1:0]           topSellQtyOut,
  output logic [$clog2(DEPTH+1)-1:0] buyLevelsOut,
  output logic [$clog2(DEPTH+1)-1:0] sellLevelsOut
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FIND   = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;

  logic [1:0] state;

  logic               buyValid [DEPTH];
  logic [PRICE_W-1:0] buyPrice [DEPTH];
  logic [QTY_W-1:0]   buyQty   [DEPTH];
  logic               sellValid [DEPTH];
  logic [PRICE_W-1:0] sellPrice [DEPTH];
  logic [QTY_W-1:0]   sellQty   [DEPTH];

  logic               mReduce, mBuy;
  logic [PRICE_W-1:0] mPrice;
  logic [QTY_W-1:0]   mShares;

  logic               selV [DEPTH];
  logic [PRICE_W-1:0] selP [DEPTH];
  logic [QTY_W-1:0]   selQ [DEPTH];
  logic               nxtV [DEPTH];
  logic [PRICE_W-1:0] nxtP [DEPTH];
  logic [QTY_W-1:0]   nxtQ [DEPTH];

  logic          hitFound, insFound, fHit, fIns;
  logic [IW-1:0] hitIdx, insIdx, fIdx, fInsIdx;
  logic          updDrop, updMiss;
  logic [QTY_W:0] satSum;
  logic [CW-1:0]  buyCnt, sellCnt;

  assign readyOut = (state == IDLE);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      selV[i] = mBuy ? buyValid[i] : sellValid[i];
      selP[i] = mBuy ? buyPrice[i] : sellPrice[i];
      selQ[i] = mBuy ? buyQty[i]   : sellQty[i];
    end
  end

  // Scan from worst to best so the lowest qualifying index wins.
  always_comb begin
    hitFound = 1'b0;
    hitIdx   = '0;
    insFound = 1'b0;
    insIdx   = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (selV[i] && selP[i] == mPrice) begin
        hitFound = 1'b1;
        hitIdx   = IW'(i);
      end
      if (!selV[i] || (mBuy ? (mPrice > selP[i]) : (mPrice < selP[i]))) begin
        insFound = 1'b1;
        insIdx   = IW'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      nxtV[i] = selV[i];
      nxtP[i] = selP[i];
      nxtQ[i] = selQ[i];
    end
    updDrop = 1'b0;
    updMiss = 1'b0;
    satSum  = {1'b0, selQ[fIdx]} + {1'b0, mShares};
    if (!mReduce) begin
      if (fHit) begin
        nxtQ[fIdx] = satSum[QTY_W] ? '1 : satSum[QTY_W-1:0];
      end else if (fIns) begin
        // Shift toward worse; a full ladder silently loses its worst level.
        for (int i = 1; i < DEPTH; i++) begin
          if (IW'(i) > fInsIdx) begin
            nxtV[i] = selV[i-1];
            nxtP[i] = selP[i-1];
            nxtQ[i] = selQ[i-1];
          end
        end
        nxtV[fInsIdx] = 1'b1;
        nxtP[fInsIdx] = mPrice;
        nxtQ[fInsIdx] = mShares;
      end else begin
        updDrop = 1'b1;
      end
    end else begin
      if (!fHit) begin
        updMiss = 1'b1;
      end else if (mShares < selQ[fIdx]) begin
        nxtQ[fIdx] = selQ[fIdx] - mShares;
      end else begin
        for (int i = 0; i < DEPTH-1; i++) begin
          if (IW'(i) >= fIdx) begin
            nxtV[i] = selV[i+1];
            nxtP[i] = selP[i+1];
            nxtQ[i] = selQ[i+1];
          end
        end
        nxtV[DEPTH-1] = 1'b0;
        nxtP[DEPTH-1] = '0;
        nxtQ[DEPTH-1] = '0;
      end
    end
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state   <= IDLE;
      mReduce <= 1'b0;
      mBuy    <= 1'b0;
      mPrice  <= '0;
      mShares <= '0;
      fHit    <= 1'b0;
      fIns    <= 1'b0;
      fIdx    <= '0;
      fInsIdx <= '0;
      doneOut <= 1'b0;
      dropOut <= 1'b0;
      missOut <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        buyValid[i]  <= 1'b0;
        buyPrice[i]  <= '0;
        buyQty[i]    <= '0;
        sellValid[i] <= 1'b0;
        sellPrice[i] <= '0;
        sellQty[i]   <= '0;
      end
    end else begin
      doneOut <= 1'b0;
      dropOut <= 1'b0;
      missOut <= 1'b0;
      case (state)
        IDLE: begin
          if (msgValidIn) begin
            mReduce <= msgReduceIn;
            mBuy    <= buySellIn;
            mPrice  <= priceIn;
            mShares <= sharesIn;
            state   <= FIND;
          end
        end
        FIND: begin
          fHit    <= hitFound;
          fIdx    <= hitIdx;
          fIns    <= insFound;
          fInsIdx <= insIdx;
          state   <= UPDATE;
        end
        UPDATE: begin
          for (int i = 0; i < DEPTH; i++) begin
            if (mBuy) begin
              buyValid[i] <= nxtV[i];
              buyPrice[i] <= nxtP[i];
              buyQty[i]   <= nxtQ[i];
            end else begin
              sellValid[i] <= nxtV[i];
              sellPrice[i] <= nxtP[i];
              sellQty[i]   <= nxtQ[i];
            end
          end
          doneOut <= 1'b1;
          dropOut <= updDrop;
          missOut <= updMiss;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    buyCnt  = '0;
    sellCnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      buyCnt  = buyCnt + CW'(buyValid[i]);
      sellCnt = sellCnt + CW'(sellValid[i]);
    end
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      topBuyValidOut  <= 1'b0;
      topSellValidOut <= 1'b0;
      topBuyPriceOut  <= '0;
      topSellPriceOut <= '0;
      topBuyQtyOut    <= '0;
      topSellQtyOut   <= '0;
      buyLevelsOut    <= '0;
      sellLevelsOut   <= '0;
    end else begin
      topBuyValidOut  <= buyValid[0];
      topSellValidOut <= sellValid[0];
      topBuyPriceOut  <= buyPrice[0];
      topSellPriceOut <= sellPrice[0];
      topBuyQtyOut    <= buyQty[0];
      topSellQtyOut   <= sellQty[0];
      buyLevelsOut    <= buyCnt;
      sellLevelsOut   <= sellCnt;
    end
  end
endmodule

// File: tb/tb_price_level_book.sv
// tb/tb_price_level_book.sv - directed bench for price_level_book
// DEPTH=4 instance so the full-ladder cases are reachable with a handful of messages.
module tb_price_level_book;
  logic        clkIn = 1'b0;
  logic        rstIn = 1'b1;
  logic        msgValidIn = 1'b0;
  logic        msgReduceIn = 1'b0;
  logic        buySellIn = 1'b0;
  logic [31:0] priceIn = '0;
  logic [31:0] sharesIn = '0;
  logic        readyOut, doneOut, dropOut, missOut;
  logic        topBuyValidOut, topSellValidOut;
  logic [31:0] topBuyPriceOut, topSellPriceOut, topBuyQtyOut, topSellQtyOut;
  logic [2:0]  buyLevelsOut, sellLevelsOut;

  int checks = 0;
  int errors = 0;

  price_level_book #(.DEPTH(4), .PRICE_W(32), .QTY_W(32)) dut (
    .clkIn(clkIn), .rstIn(rstIn), .msgValidIn(msgValidIn), .msgReduceIn(msgReduceIn),
    .buySellIn(buySellIn), .priceIn(priceIn), .sharesIn(sharesIn), .readyOut(readyOut),
    .doneOut(doneOut), .dropOut(dropOut), .missOut(missOut),
    .topBuyValidOut(topBuyValidOut), .topSellValidOut(topSellValidOut),
    .topBuyPriceOut(topBuyPriceOut), .topSellPriceOut(topSellPriceOut),
    .topBuyQtyOut(topBuyQtyOut), .topSellQtyOut(topSellQtyOut),
    .buyLevelsOut(buyLevelsOut), .sellLevelsOut(sellLevelsOut)
  );

  always #5 clkIn = ~clkIn;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clkIn);
    rstIn = 1'b1;
    @(posedge clkIn);
    @(posedge clkIn);
    #1 rstIn = 1'b0;
  endtask

  task automatic sendMsg(input string tag, input logic red, input logic buy,
                         input logic [31:0] p, input logic [31:0] s,
                         input logic expDrop, input logic expMiss);
    int waitCnt;
    waitCnt = 0;
    @(negedge clkIn);
    while (!readyOut && waitCnt < 20) begin
      @(negedge clkIn);
      waitCnt++;
    end
    chk({tag, "_ready"}, readyOut, 1);
    msgValidIn = 1'b1; msgReduceIn = red; buySellIn = buy; priceIn = p; sharesIn = s;
    @(posedge clkIn);
    #1 msgValidIn = 1'b0;
    chk({tag, "_busy"}, readyOut, 0);
    chk({tag, "_done_t1"}, doneOut, 0);
    @(posedge clkIn);
    #1 chk({tag, "_done_t1b"}, doneOut, 0);
    @(posedge clkIn);
    #1 chk({tag, "_done_t2"}, doneOut, 1);
    chk({tag, "_drop"}, dropOut, expDrop);
    chk({tag, "_miss"}, missOut, expMiss);
    @(posedge clkIn);
    #1 chk({tag, "_done_t3"}, doneOut, 0);
  endtask

  initial begin
    doReset();
    chk("rst_ready", readyOut, 1);
    chk("rst_done", doneOut, 0);
    chk("rst_bvalid", topBuyValidOut, 0);
    chk("rst_svalid", topSellValidOut, 0);
    chk("rst_bprice", topBuyPriceOut, 0);
    chk("rst_blevels", buyLevelsOut, 0);
    chk("rst_slevels", sellLevelsOut, 0);

    sendMsg("b100", 0, 1, 100, 50, 0, 0);
    sendMsg("b105", 0, 1, 105, 50, 0, 0);
    sendMsg("b102", 0, 1, 102, 50, 0, 0);
    chk("buy_top_price", topBuyPriceOut, 105);
    chk("buy_top_qty", topBuyQtyOut, 50);
    chk("buy_levels3", buyLevelsOut, 3);
    chk("buy_p1", dut.buyPrice[1], 102);
    chk("buy_p2", dut.buyPrice[2], 100);
    chk("sell_untouched", sellLevelsOut, 0);

    sendMsg("s110a", 0, 0, 110, 10, 0, 0);
    chk("sell_qty10", topSellQtyOut, 10);
    chk("sell_lv1a", sellLevelsOut, 1);
    sendMsg("s110b", 0, 0, 110, 15, 0, 0);
    chk("sell_qty25", topSellQtyOut, 25);
    chk("sell_lv1b", sellLevelsOut, 1);
    sendMsg("s110r", 1, 0, 110, 5, 0, 0);
    chk("sell_qty20", topSellQtyOut, 20);
    chk("sell_lv1c", sellLevelsOut, 1);
    chk("sell_price", topSellPriceOut, 110);

    sendMsg("r102", 1, 1, 102, 60, 0, 0);
    chk("rm_levels", buyLevelsOut, 2);
    chk("rm_top", topBuyPriceOut, 105);
    chk("rm_p1", dut.buyPrice[1], 100);
    chk("rm_q1", dut.buyQty[1], 50);
    chk("rm_v2", dut.buyValid[2], 0);
    chk("rm_p2", dut.buyPrice[2], 0);
    chk("rm_q2", dut.buyQty[2], 0);
    sendMsg("r101", 1, 1, 101, 10, 0, 1);
    chk("miss_levels", buyLevelsOut, 2);
    chk("miss_p1", dut.buyPrice[1], 100);

    doReset();
    chk("rst2_blevels", buyLevelsOut, 0);
    sendMsg("f10", 0, 1, 10, 1, 0, 0);
    sendMsg("f20", 0, 1, 20, 2, 0, 0);
    sendMsg("f30", 0, 1, 30, 3, 0, 0);
    sendMsg("f40", 0, 1, 40, 4, 0, 0);
    chk("full_levels", buyLevelsOut, 4);
    chk("full_top", topBuyPriceOut, 40);
    sendMsg("f5", 0, 1, 5, 9, 1, 0);
    chk("drop_levels", buyLevelsOut, 4);
    chk("drop_p3", dut.buyPrice[3], 10);
    sendMsg("f25", 0, 1, 25, 7, 0, 0);
    chk("ins_p0", dut.buyPrice[0], 40);
    chk("ins_p1", dut.buyPrice[1], 30);
    chk("ins_p2", dut.buyPrice[2], 25);
    chk("ins_q2", dut.buyQty[2], 7);
    chk("ins_p3", dut.buyPrice[3], 20);
    chk("ins_levels", buyLevelsOut, 4);

    sendMsg("sat_a", 0, 0, 200, 32'hFFFF_FFFE, 0, 0);
    chk("sat_pre", topSellQtyOut, 64'hFFFF_FFFE);
    sendMsg("sat_b", 0, 0, 200, 5, 0, 0);
    chk("sat_qty", topSellQtyOut, 64'hFFFF_FFFF);
    sendMsg("sat_rm", 1, 0, 200, 32'hFFFF_FFFF, 0, 0);
    chk("empty_svalid", topSellValidOut, 0);
    chk("empty_sprice", topSellPriceOut, 0);
    chk("empty_sqty", topSellQtyOut, 0);
    chk("empty_slevels", sellLevelsOut, 0);
    chk("buy_kept", topBuyPriceOut, 40);

    sendMsg("z300", 0, 0, 300, 0, 0, 0);
    chk("zero_valid", topSellValidOut, 1);
    chk("zero_qty", topSellQtyOut, 0);
    sendMsg("z300r", 1, 0, 300, 1, 0, 0);
    chk("zero_gone", sellLevelsOut, 0);
    sendMsg("emptymiss", 1, 0, 300, 1, 0, 1);

    @(negedge clkIn);
    msgValidIn = 1'b1; msgReduceIn = 1'b0; buySellIn = 1'b1; priceIn = 99; sharesIn = 10;
    @(posedge clkIn);
    #1 msgValidIn = 1'b0;
    chk("abort_in_find", readyOut, 0);
    rstIn = 1'b1;
    @(posedge clkIn);
    #1 rstIn = 1'b0;
    chk("abort_ready", readyOut, 1);
    chk("abort_done0", doneOut, 0);
    @(posedge clkIn);
    #1 chk("abort_done1", doneOut, 0);
    chk("abort_blevels", buyLevelsOut, 0);
    chk("abort_bvalid", topBuyValidOut, 0);
    @(posedge clkIn);
    #1 chk("abort_done2", doneOut, 0);
    chk("abort_v0", dut.buyValid[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/price_level_book.md
# price_level_book

Parametrised two-sided price-level order book for the market-data path. It accepts decoded add and reduce (delete/execute) messages and maintains sorted buy and sell ladders of `DEPTH` levels each, aggregating shares per price. It publishes registered top-of-book for both sides. It sits downstream of the message parser/order-map stage and generalises the single-side add-only book to two sides, configurable widths, and level removal.

## Interface
- `DEPTH`, default 8: levels per side, 2..32.
- `PRICE_W`, default 32: price width.
- `QTY_W`, default 32: aggregated quantity width.
- `clkIn`  in  1  single clock.
- `rstIn`  in  1  synchronous, active-high reset.
- `msgValidIn`  in  1  message valid; accepted when `readyOut`=1.
- `msgReduceIn`  in  1  0 = add, 1 = reduce (delete or execute).
- `buySellIn`  in  1  1 = buy side, 0 = sell side.
- `priceIn`  in  PRICE_W  level price.
- `sharesIn`  in  QTY_W  shares to add or remove.
- `readyOut`  out  1  book can accept a message this cycle.
- `doneOut`  out  1  one-cycle pulse when a message's update commits.
- `dropOut`  out  1  one-cycle pulse with `doneOut`: add fell below a full ladder.
- `missOut`  out  1  one-cycle pulse with `doneOut`: reduce price not in ladder.
- `topBuyValidOut`, `topSellValidOut`  out  1  side has at least one level.
- `topBuyPriceOut`, `topSellPriceOut`  out  PRICE_W  best price.
- `topBuyQtyOut`, `topSellQtyOut`  out  QTY_W  best-level quantity.
- `buyLevelsOut`, `sellLevelsOut`  out  $clog2(DEPTH+1)  occupied level count.

## Operation
- Per level: valid bit, price, quantity. The buy ladder is sorted by strictly descending price and the sell ladder by strictly ascending price. Index 0 is best. Valid levels are contiguous from index 0, and no price appears twice on a side.
- FSM states:
  - IDLE: `readyOut`=1. If `msgValidIn`=1, register all inputs and go to FIND.
  - FIND: compare the registered price against every level of the selected side in parallel. Produce a match flag and index, and an insert index (first invalid level, or first level worse than the new price). Register the results and go to UPDATE.
  - UPDATE: write the selected side, pulse `doneOut` (plus `dropOut`/`missOut`), and go to IDLE.
- Add, price matches: quantity = quantity + shares, saturating at 2^QTY_W-1.
- Add, no match, insert index < DEPTH: levels at or below the insert index shift one toward worse. The new level (price, shares) is written at the insert index. If the ladder was full, the worst level is discarded without a flag.
- Add, no match, ladder full, price worse than every level: no change; `dropOut`=1.
- Reduce, match, shares < quantity: quantity = quantity − shares.
- Reduce, match, shares ≥ quantity: remove the level. Levels below it shift one toward best, and the last slot is cleared (valid=0, price=0, qty=0).
- Reduce, no match, or side empty: no change; `missOut`=1.
- Add with `sharesIn`=0 is processed normally. It creates a zero-quantity level, and a later reduce of any size removes that level.
- The non-selected side is never written.

## Timing
- Throughput: one message per 3 cycles. `readyOut` is low during FIND and UPDATE.
- Input accepted at cycle edge T. `doneOut` is high in cycle T+2. Top-of-book and level counts reflect the update from edge T+3 (registered from the ladder).
- Inputs are ignored when `readyOut`=0. The upstream stage holds `msgValidIn` until it is accepted.
- Reset values:
  - All ladder entries are 0 and invalid.
  - State is IDLE; `readyOut`=1 in the cycle after reset.
  - `doneOut`, `dropOut`, `missOut`, and both valids are 0.
  - All prices, quantities, and counts are 0.
- Reset during FIND or UPDATE aborts the message. No partial write occurs and no `doneOut` is issued.
- Back-to-back messages to the same price are correct because each FIND sees the committed result of the previous UPDATE.

## Test plan
- Reset, then buy adds at prices 100, 105, 102 (50 shares each) -> buy ladder 105/102/100, `topBuyPriceOut`=105, `buyLevelsOut`=3, and `doneOut` exactly 2 cycles after each accept.
- Sell adds at 110 qty 10, then 110 qty 15, then reduce 110 qty 5 -> `topSellQtyOut` goes 10, 25, 20; `sellLevelsOut`=1 throughout.
- With DEPTH=4, fill buys at 10, 20, 30, 40 -> add 5 gives `dropOut`=1 and no change; add 25 discards 10, leaving 40/30/25/20.
- Buy ladder 105/102/100, reduce 102 qty 60 (level qty 50) -> ladder becomes 105/100, slot 2 cleared, `buyLevelsOut`=2. Then reduce 101 -> `missOut`=1, no change.
- Quantity at 2^QTY_W−2, add 5 -> quantity saturates at 2^QTY_W−1. Reduce of top sell on a one-level side -> `topSellValidOut`=0, price and qty read 0.
- Assert `rstIn` in the FIND cycle of a buy add at 99 -> no `doneOut`, book empty, `readyOut`=1 the cycle after reset deasserts.
